lcd_scanout_sequencer: RTL and testbench
========================================

Name: lcd_scanout_sequencer

Overview:
Sequences the 96x64 visible window out of the 9x132-byte LCD display RAM as a raw pixel stream for the video/blend path. It shares the RAM's single read port with CPU bus accesses; the CPU always has priority. The block applies the panel's start-line wrap, row order, segment direction, all-on, invert and display-enable settings, and emits one pixel per valid/ready handshake.

Parameters:
WIDTH, 96, visible columns per row
HEIGHT, 64, visible rows per frame
STRIDE, 132, bytes per RAM page (column count)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (reset==0 resets on the clk edge)
frame_start  in  1  one-cycle pulse that begins a frame scan
start_line  in  6  first displayed RAM line (wraps mod 64)
row_order  in  1  1 = rows displayed bottom-to-top
segment_dir  in  1  1 = column address mirrored (STRIDE-1-x)
display_enabled  in  1  0 = every pixel forced to 0
all_pixels_on  in  1  1 = every pixel forced to 1 (applied before invert)
invert_pixels  in  1  1 = pixel inverted
cpu_req  in  1  CPU wants the RAM port this cycle
cpu_gnt  out  1  CPU owns the RAM port this cycle (equals cpu_req)
ram_rd  out  1  sequencer read strobe
ram_addr  out  11  sequencer read address
ram_rdata  in  8  RAM data, valid the cycle after ram_rd
pix_valid  out  1  pixel available
pix_ready  in  1  downstream accepts the pixel
pix_data  out  1  pixel value
pix_x  out  7  pixel column 0..WIDTH-1
pix_y  out  6  pixel row 0..HEIGHT-1
busy  out  1  scan in progress
frame_done  out  1  one-cycle pulse after the last pixel is accepted
frame_overrun  out  1  one-cycle pulse when frame_start arrives while busy

Behaviour:
- Reset values: state IDLE, x=y=0, all outputs 0. cpu_gnt follows cpu_req during reset.
- FSM states: IDLE, ISSUE, CAPTURE, EMIT.
- IDLE: on frame_start, latch all config inputs into shadow registers, set x=y=0, set busy=1, go to ISSUE. Config changes mid-frame take effect at the next frame only.
- ISSUE: if cpu_req, hold with ram_rd=0 (CPU stall, no timeout). Otherwise assert ram_rd for one cycle and go to CAPTURE.
- Address computation for ISSUE:
  - ly = row_order ? (HEIGHT-1-y) : y
  - line = (ly + start_line) mod 64, using 6-bit wrap
  - page = line[5:3]; bit = line[2:0]
  - col = segment_dir ? (STRIDE-1-x) : x
  - ram_addr = page*STRIDE + col, 11-bit
  - Page 8 is never addressed.
- CAPTURE: p = ram_rdata[bit]. Then apply, in order: all_pixels_on forces p=1; invert_pixels gives p=~p; display_enabled==0 forces p=0. Register p, x, y to the pix outputs, assert pix_valid, go to EMIT.
- Latency: frame_start to first pix_valid is 3 cycles with no CPU contention. Steady state is 3 cycles per pixel when pix_ready is held high.
- EMIT: pix_valid, pix_data, pix_x and pix_y hold stable until pix_ready. On the handshake:
  - if x<WIDTH-1: x++, go to ISSUE.
  - else x=0; if y<HEIGHT-1: y++, go to ISSUE.
  - else pulse frame_done, clear busy, go to IDLE.
- A cpu_req during CAPTURE or EMIT does not disturb the pixel already fetched.
- frame_start while busy: ignored, the scan continues, frame_overrun pulses. frame_start in the same cycle as frame_done (last handshake) is treated as busy, so it is ignored and overruns.
- reset==0 mid-frame aborts immediately: pix_valid drops on the next edge, frame_done does not pulse.

Decomposition:
- Shared package lcd_pkg holds:
  - LCD_WIDTH=96, LCD_HEIGHT=64, LCD_STRIDE=132, LCD_PAGES=9
  - the scan FSM state enum
  - the lcd_cfg_t packed struct {start_line, row_order, segment_dir, display_enabled, all_pixels_on, invert_pixels}
- One natural sub-module, lcd_scan_addr_gen: combinational mapping (x, y, cfg) -> (ram_addr, bit). It is reused by any future DMA/snapshot path.

Test Plan:
1. Default config, RAM byte (page0,col0)=0x01, frame_start, pix_ready=1 -> first pixel is (0,0) data=1 at cycle 3; pixel (0,1) data=0. frame_done arrives after 6144 handshakes.
2. start_line=60, RAM page7 col5=0x10 -> pixel (5,0) reads line 60 = page7 bit4 = 1. Pixel (5,4) reads line 0 (wrap).
3. segment_dir=1, row_order=1 -> pixel (0,0) ram_addr = 7*132+131 = 1055, bit 7.
4. cpu_req held high for 10 cycles during ISSUE -> ram_rd=0 and cpu_gnt=1 throughout. The scan resumes and the pixel address is unchanged.
5. invert=1 with all_on=1 -> all pixels 0. display_enabled=0 with invert=1 -> all pixels 0. Changing config mid-frame does not alter the current frame.
6. pix_ready low for 5 cycles in EMIT -> pixel outputs stable. frame_start while busy -> frame_overrun pulse, no restart. Reset low mid-frame -> pix_valid=0, busy=0, no frame_done.

Source files
------------

// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_pkg
// Purpose  : Shared geometry constants, scan FSM state encoding and the
//            per-frame panel configuration bundle for the LCD scan-out path.
// Contents : LCD_WIDTH/LCD_HEIGHT  visible window (96 x 64)
//            LCD_STRIDE            bytes per display-RAM page (132)
//            LCD_PAGES             display-RAM pages (9; page 8 is never
//                                  scanned)
//            scan_state_t          scan FSM states
//            lcd_cfg_t             panel settings latched at frame start
// Revision : 1.0  initial release
// ============================================================================
package lcd_pkg;

  localparam int LCD_WIDTH  = 96;
  localparam int LCD_HEIGHT = 64;
  localparam int LCD_STRIDE = 132;
  localparam int LCD_PAGES  = 9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_EMIT    = 2'd3
  } scan_state_t;

  typedef struct packed {
    logic [5:0] start_line;
    logic       row_order;
    logic       segment_dir;
    logic       display_enabled;
    logic       all_pixels_on;
    logic       invert_pixels;
  } lcd_cfg_t;

endpackage
`default_nettype wire

// File: rtl/lcd_scan_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : lcd_scan_addr_gen
// Purpose  : Combinational map from a visible pixel position plus panel
//            configuration to the display-RAM byte address and the bit within
//            that byte that holds the pixel.
// Ports    : x        in   7  visible column
//            y        in   6  visible row
//            cfg      in      panel configuration (lcd_cfg_t)
//            ram_addr out 11  byte address, page*STRIDE + column
//            bit_sel  out  3  bit of the addressed byte
// Revision : 1.0  initial release
// ============================================================================
module lcd_scan_addr_gen
  import lcd_pkg::*;
#(
  parameter int STRIDE = LCD_STRIDE
) (
  input  logic [6:0]  x,
  input  logic [5:0]  y,
  input  lcd_cfg_t    cfg,
  output logic [10:0] ram_addr,
  output logic [2:0]  bit_sel
);

  localparam logic [7:0]  C_COL_MAX = 8'(STRIDE - 1);
  localparam logic [10:0] C_STRIDE  = 11'(STRIDE);

  logic [5:0] w_ly;
  logic [5:0] w_line;
  logic [7:0] w_col;

  // For a 6-bit row, HEIGHT-1-y is just the bitwise complement.
  assign w_ly   = cfg.row_order ? ~y : y;
  // 6-bit sum wraps the start-line offset modulo 64 for free.
  assign w_line = w_ly + cfg.start_line;

  assign w_col  = cfg.segment_dir ? (C_COL_MAX - {1'b0, x}) : {1'b0, x};

  assign ram_addr = ({8'd0, w_line[5:3]} * C_STRIDE) + {3'd0, w_col};
  assign bit_sel  = w_line[2:0];

endmodule
`default_nettype wire

// File: rtl/lcd_scanout_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lcd_scanout_sequencer
// Purpose  : Scans the 96x64 visible window out of the LCD display RAM as a
//            one-bit-per-pixel valid/ready stream. Shares the RAM read port
//            with the CPU, which always wins. Applies start-line wrap, row
//            order, segment direction, all-on, invert and display-enable.
// Ports    : clk, reset (sync, active-low)
//            frame_start        in   start a frame scan (pulse)
//            start_line..invert in   panel configuration, latched per frame
//            cpu_req / cpu_gnt  in/out CPU RAM-port arbitration
//            ram_rd, ram_addr   out  sequencer read request
//            ram_rdata          in   read data, one cycle after ram_rd
//            pix_valid/ready    out/in pixel handshake
//            pix_data/x/y       out  pixel value and position
//            busy               out  scan in progress
//            frame_done         out  pulse after last pixel accepted
//            frame_overrun      out  pulse on frame_start while busy
// Revision : 1.0  initial release
// ============================================================================
module lcd_scanout_sequencer
  import lcd_pkg::*;
#(
  parameter int WIDTH  = LCD_WIDTH,
  parameter int HEIGHT = LCD_HEIGHT,
  parameter int STRIDE = LCD_STRIDE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic [5:0]  start_line,
  input  logic        row_order,
  input  logic        segment_dir,
  input  logic        display_enabled,
  input  logic        all_pixels_on,
  input  logic        invert_pixels,
  input  logic        cpu_req,
  output logic        cpu_gnt,
  output logic        ram_rd,
  output logic [10:0] ram_addr,
  input  logic [7:0]  ram_rdata,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_data,
  output logic [6:0]  pix_x,
  output logic [5:0]  pix_y,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_overrun
);

  scan_state_t r_state;
  scan_state_t w_state_next;

  lcd_cfg_t    r_cfg;
  lcd_cfg_t    w_cfg_in;
  logic [6:0]  r_x;
  logic [5:0]  r_y;

  logic        w_start;
  logic        w_issue;
  logic        w_capture;
  logic        w_handshake;
  logic        w_last_col;
  logic        w_last_row;
  logic        w_frame_end;

  logic [10:0] w_addr;
  logic [2:0]  w_bit;
  logic        w_pix;

  logic        r_busy;
  logic        r_pix_valid;
  logic        r_pix_data;
  logic [6:0]  r_pix_x;
  logic [5:0]  r_pix_y;
  logic        r_frame_done;
  logic        r_frame_overrun;

  always_comb begin
    w_cfg_in                 = '0;
    w_cfg_in.start_line      = start_line;
    w_cfg_in.row_order       = row_order;
    w_cfg_in.segment_dir     = segment_dir;
    w_cfg_in.display_enabled = display_enabled;
    w_cfg_in.all_pixels_on   = all_pixels_on;
    w_cfg_in.invert_pixels   = invert_pixels;
  end

  // Address generation always sees the shadow config, so a mid-frame
  // change on the inputs cannot reach the current scan.
  lcd_scan_addr_gen #(
    .STRIDE (STRIDE)
  ) u_addr_gen (
    .x        (r_x),
    .y        (r_y),
    .cfg      (r_cfg),
    .ram_addr (w_addr),
    .bit_sel  (w_bit)
  );

  assign w_last_col  = (r_x == 7'(WIDTH - 1));
  assign w_last_row  = (r_y == 6'(HEIGHT - 1));
  assign w_frame_end = w_handshake && w_last_col && w_last_row;

  // All-on is applied before invert; display-disable overrides both.
  assign w_pix = ((r_cfg.all_pixels_on | ram_rdata[w_bit]) ^ r_cfg.invert_pixels)
                 & r_cfg.display_enabled;

  // ------------------------------------------------------------------------
  // Scan FSM
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_issue      = 1'b0;
    w_capture    = 1'b0;
    w_handshake  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (frame_start) begin
          w_start      = 1'b1;
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // CPU owns the port this cycle; wait indefinitely.
        if (!cpu_req) begin
          w_issue      = 1'b1;
          w_state_next = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        w_capture    = 1'b1;
        w_state_next = ST_EMIT;
      end
      ST_EMIT: begin
        if (pix_ready) begin
          w_handshake  = 1'b1;
          w_state_next = (w_last_col && w_last_row) ? ST_IDLE : ST_ISSUE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------------
  // Datapath
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cfg           <= '0;
      r_x             <= '0;
      r_y             <= '0;
      r_busy          <= 1'b0;
      r_pix_valid     <= 1'b0;
      r_pix_data      <= 1'b0;
      r_pix_x         <= '0;
      r_pix_y         <= '0;
      r_frame_done    <= 1'b0;
      r_frame_overrun <= 1'b0;
    end else begin
      r_frame_done    <= w_frame_end;
      // Any state other than IDLE counts as busy, including the cycle of
      // the final handshake.
      r_frame_overrun <= frame_start && (r_state != ST_IDLE);

      if (w_start) begin
        r_cfg  <= w_cfg_in;
        r_x    <= '0;
        r_y    <= '0;
        r_busy <= 1'b1;
      end

      if (w_capture) begin
        r_pix_valid <= 1'b1;
        r_pix_data  <= w_pix;
        r_pix_x     <= r_x;
        r_pix_y     <= r_y;
      end

      if (w_handshake) begin
        r_pix_valid <= 1'b0;
        if (!w_last_col) begin
          r_x <= r_x + 7'd1;
        end else begin
          r_x <= '0;
          if (!w_last_row) begin
            r_y <= r_y + 6'd1;
          end else begin
            r_y    <= '0;
            r_busy <= 1'b0;
          end
        end
      end
    end
  end

  assign cpu_gnt       = cpu_req;
  assign ram_rd        = w_issue;
  assign ram_addr      = w_issue ? w_addr : '0;
  assign pix_valid     = r_pix_valid;
  assign pix_data      = r_pix_data;
  assign pix_x         = r_pix_x;
  assign pix_y         = r_pix_y;
  assign busy          = r_busy;
  assign frame_done    = r_frame_done;
  assign frame_overrun = r_frame_overrun;

endmodule
`default_nettype wire

// File: tb/tb_lcd_scanout_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_scanout_sequencer
// Purpose  : Directed self-checking bench for lcd_scanout_sequencer with a
//            behavioural display RAM and an independent pixel model.
// Revision : 1.0  initial release
// ============================================================================
module tb_lcd_scanout_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        frame_start = 1'b0;
  logic [5:0]  start_line = '0;
  logic        row_order = 1'b0;
  logic        segment_dir = 1'b0;
  logic        display_enabled = 1'b1;
  logic        all_pixels_on = 1'b0;
  logic        invert_pixels = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_gnt;
  logic        ram_rd;
  logic [10:0] ram_addr;
  logic [7:0]  ram_rdata = '0;
  logic        pix_valid;
  logic        pix_ready = 1'b0;
  logic        pix_data;
  logic [6:0]  pix_x;
  logic [5:0]  pix_y;
  logic        busy;
  logic        frame_done;
  logic        frame_overrun;

  lcd_scanout_sequencer u_dut (
    .clk             (clk),
    .reset           (reset),
    .frame_start     (frame_start),
    .start_line      (start_line),
    .row_order       (row_order),
    .segment_dir     (segment_dir),
    .display_enabled (display_enabled),
    .all_pixels_on   (all_pixels_on),
    .invert_pixels   (invert_pixels),
    .cpu_req         (cpu_req),
    .cpu_gnt         (cpu_gnt),
    .ram_rd          (ram_rd),
    .ram_addr        (ram_addr),
    .ram_rdata       (ram_rdata),
    .pix_valid       (pix_valid),
    .pix_ready       (pix_ready),
    .pix_data        (pix_data),
    .pix_x           (pix_x),
    .pix_y           (pix_y),
    .busy            (busy),
    .frame_done      (frame_done),
    .frame_overrun   (frame_overrun)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:1187];
  always @(posedge clk) begin
    if (ram_rd) ram_rdata <= mem[ram_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Configuration as seen by the bench at frame start.
  int   m_sl;
  bit   m_ro, m_sd, m_de, m_ao, m_inv;

  function automatic logic exp_pix(input int x, input int y);
    int ly, line, col;
    logic [7:0] bv;
    logic p;
    ly   = m_ro ? (63 - y) : y;
    line = (ly + m_sl) % 64;
    col  = m_sd ? (131 - x) : x;
    bv   = mem[(line / 8) * 132 + col];
    p    = bv[line % 8];
    if (m_ao) p = 1'b1;
    if (m_inv) p = ~p;
    if (!m_de) p = 1'b0;
    return p;
  endfunction

  logic img [0:63][0:95];
  int hs, done_cnt, ovr_cnt, done_k, first_k, first_addr, bad, ones;

  task automatic clear_mem(input bit rnd);
    for (int i = 0; i < 1188; i++) mem[i] = rnd ? 8'($urandom) : 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b0; frame_start = 1'b0; pix_ready = 1'b0; cpu_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic set_cfg(input int sl, input bit ro, input bit sd, input bit de, input bit ao, input bit inv);
    start_line = 6'(sl); row_order = ro; segment_dir = sd;
    display_enabled = de; all_pixels_on = ao; invert_pixels = inv;
  endtask

  // Starts a frame with pix_ready high and collects statistics. max_pix=0
  // runs to frame_done; otherwise stops after that many handshakes.
  task automatic run_frame(input bit cpu_pat, input bit chg_cfg, input bit late_start, input int max_pix);
    int k;
    hs = 0; done_cnt = 0; ovr_cnt = 0; done_k = -1; first_k = -1;
    first_addr = -1; bad = 0; ones = 0;
    for (int y = 0; y < 64; y++) for (int x = 0; x < 96; x++) img[y][x] = 1'b0;
    m_sl = int'(start_line); m_ro = row_order; m_sd = segment_dir;
    m_de = display_enabled; m_ao = all_pixels_on; m_inv = invert_pixels;
    pix_ready = 1'b1; frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    k = 0;
    while (k < 30000) begin
      if (max_pix != 0 && hs >= max_pix) break;
      if (done_k >= 0 && k >= done_k + 3) break;
      if (ram_rd && first_addr < 0) first_addr = int'(ram_addr);
      if (pix_valid && first_k < 0) first_k = k;
      if (frame_done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (frame_overrun) ovr_cnt++;
      frame_start = 1'b0;
      if (pix_valid && pix_ready) begin
        hs++;
        if (pix_x < 96) img[pix_y][pix_x] = pix_data;
        if (pix_data !== exp_pix(int'(pix_x), int'(pix_y))) bad++;
        if (pix_data === 1'b1) ones++;
        if (late_start && pix_x == 7'd95 && pix_y == 6'd63) frame_start = 1'b1;
      end
      cpu_req = cpu_pat && (k % 5 == 1);
      if (chg_cfg && k == 50) begin
        all_pixels_on = ~all_pixels_on;
        invert_pixels = ~invert_pixels;
        start_line    = start_line + 6'd7;
      end
      @(posedge clk); #1;
      k++;
    end
    pix_ready = 1'b0; frame_start = 1'b0; cpu_req = 1'b0;
  endtask

  initial begin
    int n, stall_bad, stable_bad, ovr, stray;
    logic [13:0] snap;

    // ---------------- reset state ----------------
    cpu_req = 1'b1;
    #1;
    check_value("rst_cpu_gnt", 32'(cpu_gnt), 32'd1);
    @(posedge clk); #1;
    check_value("rst_outputs",
                32'({ram_rd, ram_addr, pix_valid, pix_data, pix_x, pix_y, busy, frame_done, frame_overrun}),
                32'd0);
    do_reset();

    // ---------------- 1: default config, full frame ----------------
    clear_mem(1'b1);
    mem[0] = 8'h01;
    set_cfg(0, 0, 0, 1, 0, 0);
    run_frame(1'b0, 1'b0, 1'b1, 0);
    // frame_start in cycle 0 -> pix_valid in cycle 3, i.e. 2 edges after the sampling edge
    check_value("t1_first_latency", 32'(first_k), 32'd2);
    check_value("t1_first_addr", 32'(first_addr), 32'd0);
    check_value("t1_pix_0_0", 32'(img[0][0]), 32'd1);
    check_value("t1_pix_0_1", 32'(img[1][0]), 32'd0);
    check_value("t1_handshakes", 32'(hs), 32'd6144);
    check_value("t1_done_cycle", 32'(done_k), 32'd18432);
    check_value("t1_done_pulses", 32'(done_cnt), 32'd1);
    check_value("t1_late_overrun", 32'(ovr_cnt), 32'd1);
    check_value("t1_model_bad", 32'(bad), 32'd0);
    check_value("t1_idle_after", 32'({busy, pix_valid}), 32'd0);
    do_reset();

    // ---------------- 2: start-line wrap with CPU traffic ----------------
    clear_mem(1'b0);
    mem[7 * 132 + 5] = 8'h10;
    mem[5]           = 8'h01;
    set_cfg(60, 0, 0, 1, 0, 0);
    run_frame(1'b1, 1'b0, 1'b0, 480);
    check_value("t2_pix_5_0", 32'(img[0][5]), 32'd1);
    check_value("t2_pix_5_1", 32'(img[1][5]), 32'd0);
    check_value("t2_pix_5_4_wrap", 32'(img[4][5]), 32'd1);
    check_value("t2_pix_4_0", 32'(img[0][4]), 32'd0);
    check_value("t2_model_bad", 32'(bad), 32'd0);
    do_reset();

    // ---------------- 3: mirrored segments, bottom-to-top ----------------
    clear_mem(1'b0);
    mem[1055] = 8'h80;
    set_cfg(0, 1, 1, 1, 0, 0);
    run_frame(1'b0, 1'b0, 1'b0, 2);
    check_value("t3_first_addr", 32'(first_addr), 32'd1055);
    check_value("t3_pix_0_0", 32'(img[0][0]), 32'd1);
    check_value("t3_model_bad", 32'(bad), 32'd0);
    do_reset();

    // ---------------- 4: CPU stall in ISSUE ----------------
    clear_mem(1'b0);
    mem[131] = 8'h01;
    set_cfg(0, 0, 1, 1, 0, 0);
    cpu_req = 1'b1; frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    stall_bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (ram_rd !== 1'b0 || cpu_gnt !== 1'b1 || pix_valid !== 1'b0) stall_bad++;
      @(posedge clk); #1;
    end
    check_value("t4_stall_hold", 32'(stall_bad), 32'd0);
    cpu_req = 1'b0;
    #1;
    check_value("t4_resume_rd", 32'(ram_rd), 32'd1);
    check_value("t4_resume_addr", 32'(ram_addr), 32'd131);
    pix_ready = 1'b1;
    n = 0;
    while (!pix_valid && n < 10) begin @(posedge clk); #1; n++; end
    check_value("t4_pixel", 32'({pix_valid, pix_data, pix_x, pix_y}), 32'({1'b1, 1'b1, 7'd0, 6'd0}));
    do_reset();

    // ---------------- 5: invert/all-on/disable, mid-frame config change ----
    clear_mem(1'b1);
    set_cfg(0, 0, 0, 1, 1, 1);
    run_frame(1'b0, 1'b1, 1'b0, 0);
    check_value("t5_inv_allon_ones", 32'(ones), 32'd0);
    check_value("t5_inv_allon_bad", 32'(bad), 32'd0);
    check_value("t5_inv_allon_hs", 32'(hs), 32'd6144);
    do_reset();
    set_cfg(0, 0, 0, 0, 0, 1);
    run_frame(1'b0, 1'b0, 1'b0, 300);
    check_value("t5_disabled_ones", 32'(ones), 32'd0);
    check_value("t5_disabled_hs", 32'(hs), 32'd300);
    do_reset();

    // ---------------- 6: backpressure, overrun, abort ----------------
    clear_mem(1'b0);
    mem[0] = 8'h01;
    set_cfg(0, 0, 0, 1, 0, 0);
    pix_ready = 1'b0; frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    n = 0;
    while (!pix_valid && n < 10) begin @(posedge clk); #1; n++; end
    check_value("t6_valid", 32'(pix_valid), 32'd1);
    snap = {pix_data, pix_x, pix_y};
    stable_bad = 0; ovr = 0;
    for (int i = 0; i < 5; i++) begin
      frame_start = (i == 1);
      @(posedge clk); #1;
      if (frame_overrun) ovr++;
      if ({pix_valid, pix_data, pix_x, pix_y} !== {1'b1, snap}) stable_bad++;
    end
    frame_start = 1'b0;
    check_value("t6_stable", 32'(stable_bad), 32'd0);
    check_value("t6_snapshot", 32'(snap), 32'({1'b1, 7'd0, 6'd0}));
    check_value("t6_overrun", 32'(ovr), 32'd1);
    check_value("t6_still_busy", 32'(busy), 32'd1);
    pix_ready = 1'b1;
    @(posedge clk); #1;
    pix_ready = 1'b0;
    n = 0;
    while (!pix_valid && n < 10) begin @(posedge clk); #1; n++; end
    check_value("t6_next_pixel", 32'({pix_valid, pix_data, pix_x, pix_y}), 32'({1'b1, 1'b0, 7'd1, 6'd0}));
    reset = 1'b0;
    @(posedge clk); #1;
    check_value("t6_abort", 32'({pix_valid, busy, frame_done}), 32'd0);
    reset = 1'b1;
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (frame_done || pix_valid || busy) stray++;
    end
    check_value("t6_no_done_after_abort", 32'(stray), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
